// File: rtl/atomrvcore_pkg.sv
// atomrvcore_pkg: shared types and constants for the atomRVCORE load/store unit.
//   lsu_state_t    - LSU control FSM states
//   lsu_size_t     - RV32 load/store funct3 size codes
//   BE_*           - unshifted byte-enable patterns
//   lsu_misaligned - true when an access crosses its natural alignment
package atomrvcore_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2
  } lsu_state_t;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } lsu_size_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Reserved size codes are word accesses, so they need word alignment too.
  function automatic logic lsu_misaligned(input logic [2:0] size, input logic [1:0] lo);
    logic mis;
    case (size)
      SZ_B, SZ_BU: mis = 1'b0;
      SZ_H, SZ_HU: mis = lo[0];
      default:     mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/atomrvcore_lsu_align.sv
// atomrvcore_lsu_align: combinational lane logic for the LSU.
//   Store side: i_st_size/i_st_lo/i_st_data -> o_st_be (byte enables), o_st_wdata (replicated data)
//   Load side:  i_ld_size/i_ld_lo/i_ld_rdata -> o_ld_data (lane-selected, sign/zero extended)
module atomrvcore_lsu_align
  import atomrvcore_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic [2:0]           i_st_size,
  input  logic [1:0]           i_st_lo,
  input  logic [DATAWIDTH-1:0] i_st_data,
  output logic [3:0]           o_st_be,
  output logic [DATAWIDTH-1:0] o_st_wdata,
  input  logic [2:0]           i_ld_size,
  input  logic [1:0]           i_ld_lo,
  input  logic [DATAWIDTH-1:0] i_ld_rdata,
  output logic [DATAWIDTH-1:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store: replicate the datum across every lane it could land in; BE picks the lane.
  always_comb begin
    o_st_be    = BE_WORD;
    o_st_wdata = i_st_data;
    case (i_st_size)
      SZ_B, SZ_BU: begin
        o_st_be    = 4'(BE_BYTE << i_st_lo);
        o_st_wdata = {4{i_st_data[7:0]}};
      end
      SZ_H, SZ_HU: begin
        o_st_be    = 4'(BE_HALF << {i_st_lo[1], 1'b0});
        o_st_wdata = {2{i_st_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load: halfword lane uses addr[1] only, so an odd halfword address aligns down.
  assign w_byte = i_ld_rdata[{i_ld_lo, 3'b000} +: 8];
  assign w_half = i_ld_lo[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];

  always_comb begin
    o_ld_data = i_ld_rdata;
    case (i_ld_size)
      SZ_B:    o_ld_data = {{(DATAWIDTH-8){w_byte[7]}}, w_byte};
      SZ_BU:   o_ld_data = {{(DATAWIDTH-8){1'b0}}, w_byte};
      SZ_H:    o_ld_data = {{(DATAWIDTH-16){w_half[15]}}, w_half};
      SZ_HU:   o_ld_data = {{(DATAWIDTH-16){1'b0}}, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/atomrvcore_lsu.sv
// atomrvcore_lsu: load/store unit after the ALU stage.
//   Upstream:  valid_i, result_i, address_i, DR_EN_i, DWR_EN_i, size_i, R2_i, RD_i, RWR_EN_i; stall_o
//   Memory:    data_req_o, data_we_o, data_addr_o, data_be_o, data_wdata_o;
//              data_gnt_i, data_rvalid_i, data_rdata_i
//   Writeback: wb_valid_o, wb_data_o, RD_o, RWR_EN_o, misalign_o
// Optional: define ATOMRV_LSU_MISALIGN_TRAP_EN to flag misaligned H/W accesses
// instead of issuing them aligned down.
module atomrvcore_lsu
  import atomrvcore_pkg::*;
#(
  parameter int unsigned DATAWIDTH        = 32,
  parameter int unsigned REG_ADRESS_WIDTH = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        valid_i,
  input  logic [DATAWIDTH-1:0]        result_i,
  input  logic [DATAWIDTH-1:0]        address_i,
  input  logic                        DR_EN_i,
  input  logic                        DWR_EN_i,
  input  logic [2:0]                  size_i,
  input  logic [DATAWIDTH-1:0]        R2_i,
  input  logic [REG_ADRESS_WIDTH-1:0] RD_i,
  input  logic                        RWR_EN_i,
  output logic                        stall_o,
  output logic                        data_req_o,
  output logic                        data_we_o,
  output logic [DATAWIDTH-1:0]        data_addr_o,
  output logic [3:0]                  data_be_o,
  output logic [DATAWIDTH-1:0]        data_wdata_o,
  input  logic                        data_gnt_i,
  input  logic                        data_rvalid_i,
  input  logic [DATAWIDTH-1:0]        data_rdata_i,
  output logic                        wb_valid_o,
  output logic [DATAWIDTH-1:0]        wb_data_o,
  output logic [REG_ADRESS_WIDTH-1:0] RD_o,
  output logic                        RWR_EN_o,
  output logic                        misalign_o
);

  lsu_state_t                  r_state, w_state_nxt;
  logic [2:0]                  r_size, w_size_nxt;
  logic [1:0]                  r_lo, w_lo_nxt;
  logic [REG_ADRESS_WIDTH-1:0] r_rd, w_rd_nxt;
  logic                        r_rwr, w_rwr_nxt;

  logic                        w_req_nxt, w_we_nxt, w_wb_valid_nxt, w_rwr_o_nxt, w_mis_nxt;
  logic [DATAWIDTH-1:0]        w_addr_nxt, w_wdata_nxt, w_wb_data_nxt;
  logic [3:0]                  w_be_nxt;
  logic [REG_ADRESS_WIDTH-1:0] w_rd_o_nxt;

  logic [3:0]                  w_st_be;
  logic [DATAWIDTH-1:0]        w_st_wdata, w_ld_data;
  logic                        w_is_mem, w_misalign;

  atomrvcore_lsu_align #(.DATAWIDTH(DATAWIDTH)) u_align (
    .i_st_size  (size_i),
    .i_st_lo    (address_i[1:0]),
    .i_st_data  (R2_i),
    .o_st_be    (w_st_be),
    .o_st_wdata (w_st_wdata),
    .i_ld_size  (r_size),
    .i_ld_lo    (r_lo),
    .i_ld_rdata (data_rdata_i),
    .o_ld_data  (w_ld_data)
  );

  assign w_is_mem = DR_EN_i | DWR_EN_i;
  assign stall_o  = (r_state != IDLE);

`ifdef ATOMRV_LSU_MISALIGN_TRAP_EN
  assign w_misalign = lsu_misaligned(size_i, address_i[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  // Next-state and next-output logic; outputs hold unless a transition updates them.
  always_comb begin
    w_state_nxt    = r_state;
    w_size_nxt     = r_size;
    w_lo_nxt       = r_lo;
    w_rd_nxt       = r_rd;
    w_rwr_nxt      = r_rwr;
    w_req_nxt      = data_req_o;
    w_we_nxt       = data_we_o;
    w_addr_nxt     = data_addr_o;
    w_be_nxt       = data_be_o;
    w_wdata_nxt    = data_wdata_o;
    w_wb_valid_nxt = 1'b0;
    w_wb_data_nxt  = wb_data_o;
    w_rd_o_nxt     = RD_o;
    w_rwr_o_nxt    = RWR_EN_o;
    w_mis_nxt      = 1'b0;

    case (r_state)
      IDLE: begin
        if (valid_i) begin
          if (!w_is_mem) begin
            w_wb_valid_nxt = 1'b1;
            w_wb_data_nxt  = result_i;
            w_rd_o_nxt     = RD_i;
            w_rwr_o_nxt    = RWR_EN_i;
          end else if (w_misalign) begin
            w_wb_valid_nxt = 1'b1;
            w_rd_o_nxt     = RD_i;
            w_rwr_o_nxt    = 1'b0;
            w_mis_nxt      = 1'b1;
          end else begin
            // Store wins when both enables are set.
            w_size_nxt  = size_i;
            w_lo_nxt    = address_i[1:0];
            w_rd_nxt    = RD_i;
            w_rwr_nxt   = RWR_EN_i;
            w_req_nxt   = 1'b1;
            w_we_nxt    = DWR_EN_i;
            w_addr_nxt  = {address_i[DATAWIDTH-1:2], 2'b00};
            w_be_nxt    = w_st_be;
            w_wdata_nxt = w_st_wdata;
            w_state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (data_gnt_i) begin
          w_req_nxt = 1'b0;
          w_we_nxt  = 1'b0;
          if (data_we_o) begin
            w_wb_valid_nxt = 1'b1;
            w_rd_o_nxt     = r_rd;
            w_rwr_o_nxt    = 1'b0;
            w_state_nxt    = IDLE;
          end else begin
            w_state_nxt = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (data_rvalid_i) begin
          w_wb_valid_nxt = 1'b1;
          w_wb_data_nxt  = w_ld_data;
          w_rd_o_nxt     = r_rd;
          w_rwr_o_nxt    = r_rwr;
          w_state_nxt    = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, capture and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_size       <= '0;
      r_lo         <= '0;
      r_rd         <= '0;
      r_rwr        <= 1'b0;
      data_req_o   <= 1'b0;
      data_we_o    <= 1'b0;
      data_addr_o  <= '0;
      data_be_o    <= '0;
      data_wdata_o <= '0;
      wb_valid_o   <= 1'b0;
      wb_data_o    <= '0;
      RD_o         <= '0;
      RWR_EN_o     <= 1'b0;
      misalign_o   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_size       <= w_size_nxt;
      r_lo         <= w_lo_nxt;
      r_rd         <= w_rd_nxt;
      r_rwr        <= w_rwr_nxt;
      data_req_o   <= w_req_nxt;
      data_we_o    <= w_we_nxt;
      data_addr_o  <= w_addr_nxt;
      data_be_o    <= w_be_nxt;
      data_wdata_o <= w_wdata_nxt;
      wb_valid_o   <= w_wb_valid_nxt;
      wb_data_o    <= w_wb_data_nxt;
      RD_o         <= w_rd_o_nxt;
      RWR_EN_o     <= w_rwr_o_nxt;
      misalign_o   <= w_mis_nxt;
    end
  end

endmodule
